mem_ar_arbiter: RTL and testbench
=================================

MEM_AR_ARBITER -- requirements
Module: mem_ar_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 64, address width; ID_W, default 16, AXI ID width; TID_W, default 10, transaction-ID width; MAX_OUT, default 8, maximum outstanding reads (power of 2 or not, 1..255).
REQ-002 Clocking SHALL be: one clock; reset is asynchronous and active-high.
REQ-003 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, async active-high reset.
- mfifo_aempty_i, in, 1, read-miss FIFO (source 0) almost-empty.
- mfifo_rden_o, out, 1, source 0 read strobe.
- mfifo_data_i, in, TID_W+ADDR_W, source 0 data {tid, addr}.
- pfifo_aempty_i, in, 1, prefetch FIFO (source 1) almost-empty.
- pfifo_rden_o, out, 1, source 1 read strobe.
- pfifo_data_i, in, TID_W+ADDR_W, source 1 data {tid, addr}.
- arid_o, out, ID_W, AXI AR ID.
- araddr_o, out, ADDR_W, AXI AR address.
- arvalid_o, out, 1, AXI AR valid.
- arready_i, in, 1, AXI AR ready.
- rmfifo_afull_i, in, 1, miss-tracking FIFO almost-full.
- rmfifo_wren_o, out, 1, miss-tracking FIFO write strobe.
- rmfifo_data_o, out, 1+TID_W+ADDR_W, tracking entry {src, tid, addr}.
- rdone_i, in, 1, one-cycle pulse per completed read burst (RLAST accepted).
- err_o, out, 1, sticky error flag.

Function
REQ-004 The FSM SHALL have states S_IDLE, S_LOAD, S_ISSUE; reset state is S_IDLE.
REQ-005 In S_IDLE, a grant SHALL occur when all hold: at least one aempty_i low, rmfifo_afull_i low, outstanding count < MAX_OUT.
- On a grant, exactly one rden_o is high for one cycle, and the next state is S_LOAD.
- Otherwise the FSM stays in S_IDLE and no rden_o is asserted.
REQ-006 Arbitration SHALL be round-robin.
- rr_ptr (reset 0) names the preferred source.
- If only one source is non-empty, that source wins regardless of rr_ptr.
REQ-007 FIFO read data SHALL be valid the cycle after rden_o.
- In S_LOAD the block registers {src, tid, addr} from the granted source.
- Next state is S_ISSUE.
REQ-008 In S_ISSUE, arvalid_o SHALL be 1, with:
- araddr_o = registered addr.
- arid_o = {src, zeros, tid}: src in bit ID_W-1, tid in bits TID_W-1:0.
- arid_o and araddr_o held stable until arready_i=1.
REQ-009 On the S_ISSUE cycle with arready_i=1, the block SHALL in the same cycle:
- Pulse rmfifo_wren_o with rmfifo_data_o = {src, tid, addr}.
- Increment the outstanding count.
- Set rr_ptr to ~src.
- Return to S_IDLE.
REQ-010 Grant-to-first-arvalid latency SHALL be 2 cycles. Minimum spacing between consecutive AR handshakes SHALL be 3 cycles.
REQ-011 The outstanding counter SHALL be $clog2(MAX_OUT+1) bits wide.
- Handshake only: +1.
- rdone_i only: -1.
- Both in the same cycle: unchanged.
REQ-012 If rdone_i arrives with count=0, the counter SHALL stay 0 and err_o SHALL set; err_o clears only on reset.
REQ-013 rmfifo_afull_i and aempty_i changes SHALL only affect new grants; a transaction already in S_LOAD/S_ISSUE completes.
REQ-014 When arready_i=1 on S_ISSUE entry, the handshake SHALL complete in that same cycle. There are no arvalid_o bubbles and no arvalid_o deassertion before the handshake.

Reset
REQ-015 While rst=1, the block SHALL hold all outputs at 0: arvalid_o, rden_o, rmfifo_wren_o, arid_o, araddr_o, rmfifo_data_o, err_o. Counter and rr_ptr are also 0 and the FSM is in S_IDLE.
REQ-016 Reset asserted mid-transaction SHALL drop arvalid_o asynchronously; the in-flight request and count are discarded.

Structure
REQ-017 ADDR_W, ID_W, TID_W defaults, the state enum, and a packed {src, tid, addr} entry typedef SHALL live in a shared package dram_cache_pkg.
REQ-018 The outstanding counter SHALL be a sub-module, rd_credit_cnt (inc, dec, count, full, err).

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Single miss: src0 {tid=1, addr=0x1}, arready=1 -> arvalid on cycle 2 after rden; arid=0x0001, araddr=0x1; rmfifo_data={0,1,0x1}; count=1.
- Both sources non-empty continuously, rdone pulsed per issue -> grants alternate src0, src1, src0, ...; arid bit15 toggles each handshake.
- arready held 0 for 5 cycles -> arvalid/arid/araddr stable for 5 cycles; single wren on the handshake cycle.
- MAX_OUT=2, no rdone -> third grant blocked. One rdone pulse -> grant the next cycle. rdone coincident with a handshake -> count unchanged.
- rmfifo_afull=1 with src1 non-empty -> no rden; deassert -> grant within 1 cycle.
- rdone with count=0 -> err_o=1 and sticky. Reset during S_ISSUE -> arvalid 0 immediately; err_o cleared.

Source files
------------

// File: rtl/dram_cache_pkg.sv
// Shared types and defaults for the DRAM-cache read path: FSM states, tracking
// entry layout and the round-robin pick between the miss and prefetch sources.
package dram_cache_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int ID_W_DEF   = 16;
  localparam int TID_W_DEF  = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ISSUE = 2'd2
  } ar_state_t;

  typedef struct packed {
    logic                 src;
    logic [TID_W_DEF-1:0] tid;
    logic [ADDR_W_DEF-1:0] addr;
  } rd_entry_t;

  // pref only matters when both sources have data; otherwise the non-empty one wins
  function automatic logic rr_pick(input logic pref, input logic v0, input logic v1);
    return (v0 && v1) ? pref : v1;
  endfunction

endpackage

// File: rtl/rd_credit_cnt.sv
// Outstanding-read counter: +1 per AR handshake, -1 per completed burst.
// An underflowing completion leaves the count at zero and latches err.
module rd_credit_cnt #(
  parameter int MAX_OUT = 8,
  parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             err
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (inc && !dec)
        count <= count + 1'b1;
      else if (dec && !inc && (count != '0))
        count <= count - 1'b1;
      if (dec && (count == '0))
        err <= 1'b1;
    end
  end

  assign full = (count >= CNT_W'(MAX_OUT));

endmodule

// File: rtl/mem_ar_arbiter.sv
// Round-robin arbiter between the read-miss and prefetch FIFOs feeding one AXI AR
// channel; each issued read is logged to the miss-tracking FIFO on handshake.
module mem_ar_arbiter
  import dram_cache_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int ID_W    = ID_W_DEF,
  parameter int TID_W   = TID_W_DEF,
  parameter int MAX_OUT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mfifo_aempty_i,
  output logic                    mfifo_rden_o,
  input  logic [TID_W+ADDR_W-1:0] mfifo_data_i,
  input  logic                    pfifo_aempty_i,
  output logic                    pfifo_rden_o,
  input  logic [TID_W+ADDR_W-1:0] pfifo_data_i,
  output logic [ID_W-1:0]         arid_o,
  output logic [ADDR_W-1:0]       araddr_o,
  output logic                    arvalid_o,
  input  logic                    arready_i,
  input  logic                    rmfifo_afull_i,
  output logic                    rmfifo_wren_o,
  output logic [TID_W+ADDR_W:0]   rmfifo_data_o,
  input  logic                    rdone_i,
  output logic                    err_o
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int ENT_W = 1 + TID_W + ADDR_W;

  ar_state_t        state;
  logic             sel_src;
  logic             rr_ptr;
  logic [ENT_W-1:0] entry_q;
  logic             arvalid_q;
  logic [CNT_W-1:0] out_cnt;
  logic             cnt_full;
  logic             cnt_err;
  logic             can_grant;
  logic             grant_src;
  logic             handshake;

  // rden must be combinational so the FIFO data lands in S_LOAD; gated by rst
  // so nothing is popped while the block is held in reset.
  assign can_grant = (state == S_IDLE) && !rst && (!mfifo_aempty_i || !pfifo_aempty_i) &&
                     !rmfifo_afull_i && !cnt_full;
  assign grant_src = rr_pick(rr_ptr, !mfifo_aempty_i, !pfifo_aempty_i);
  assign mfifo_rden_o = can_grant && !grant_src;
  assign pfifo_rden_o = can_grant && grant_src;
  assign handshake    = arvalid_q && arready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      sel_src   <= 1'b0;
      rr_ptr    <= 1'b0;
      entry_q   <= '0;
      arvalid_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (can_grant) begin
            sel_src <= grant_src;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          entry_q   <= {sel_src, (sel_src ? pfifo_data_i : mfifo_data_i)};
          arvalid_q <= 1'b1;
          state     <= S_ISSUE;
        end
        S_ISSUE: begin
          if (arready_i) begin
            arvalid_q <= 1'b0;
            rr_ptr    <= ~entry_q[ENT_W-1];
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  rd_credit_cnt #(
    .MAX_OUT (MAX_OUT),
    .CNT_W   (CNT_W)
  ) u_credit (
    .clk   (clk),
    .rst   (rst),
    .inc   (handshake),
    .dec   (rdone_i),
    .count (out_cnt),
    .full  (cnt_full),
    .err   (cnt_err)
  );

  // Source bit sits at the top of the ID so responses can be steered back
  always_comb begin
    arid_o              = '0;
    arid_o[ID_W-1]      = entry_q[ENT_W-1];
    arid_o[TID_W-1:0]   = entry_q[ADDR_W +: TID_W];
  end

  assign araddr_o      = entry_q[ADDR_W-1:0];
  assign arvalid_o     = arvalid_q;
  assign rmfifo_wren_o = handshake;
  assign rmfifo_data_o = entry_q;
  assign err_o         = cnt_err;

endmodule

// File: tb/tb_mem_ar_arbiter.sv
// Bench for mem_ar_arbiter: FIFO sources emulated with queues, expectations from a
// transaction-level model (grant rules, 2-cycle issue latency, credit arithmetic).
module tb_mem_ar_arbiter;

  localparam int AW  = 64;
  localparam int TW  = 10;
  localparam int IDW = 16;
  localparam int MO  = 2;
  localparam int DW  = TW + AW;
  localparam int EW  = 1 + DW;

  logic           clk, rst;
  logic           mfifo_aempty_i, pfifo_aempty_i;
  logic           mfifo_rden_o, pfifo_rden_o;
  logic [DW-1:0]  mfifo_data_i, pfifo_data_i;
  logic [IDW-1:0] arid_o;
  logic [AW-1:0]  araddr_o;
  logic           arvalid_o, arready_i;
  logic           rmfifo_afull_i, rmfifo_wren_o;
  logic [EW-1:0]  rmfifo_data_o;
  logic           rdone_i, err_o;

  mem_ar_arbiter #(.ADDR_W(AW), .ID_W(IDW), .TID_W(TW), .MAX_OUT(MO)) dut (
    .clk(clk), .rst(rst),
    .mfifo_aempty_i(mfifo_aempty_i), .mfifo_rden_o(mfifo_rden_o), .mfifo_data_i(mfifo_data_i),
    .pfifo_aempty_i(pfifo_aempty_i), .pfifo_rden_o(pfifo_rden_o), .pfifo_data_i(pfifo_data_i),
    .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rmfifo_afull_i(rmfifo_afull_i), .rmfifo_wren_o(rmfifo_wren_o), .rmfifo_data_o(rmfifo_data_o),
    .rdone_i(rdone_i), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic          pend0, pend1;
  logic [DW-1:0] pop0, pop1;

  logic          m_busy, m_src, m_rr, m_err;
  int            m_age, m_cnt;
  logic [DW-1:0] m_item;

  logic           s_rden0, s_rden1, s_arvalid, s_wren, s_err;
  logic [IDW-1:0] s_arid;
  logic [AW-1:0]  s_araddr;
  logic [EW-1:0]  s_rdata;
  logic           e_rden0, e_rden1, e_arvalid, e_wren, e_err;
  logic [IDW-1:0] e_arid;
  logic [AW-1:0]  e_araddr;
  logic [EW-1:0]  e_rdata;

  function automatic logic [DW-1:0] rand_item();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  task automatic drive_fifo();
    mfifo_aempty_i = (q0.size() == 0);
    pfifo_aempty_i = (q1.size() == 0);
    mfifo_data_i   = pend0 ? pop0 : rand_item();
    pfifo_data_i   = pend1 ? pop1 : rand_item();
    pend0 = 1'b0;
    pend1 = 1'b0;
  endtask

  // One clock: sample DUT mid-cycle, form model expectations, advance both.
  task automatic tick();
    logic nz0, nz1, g, gsrc;
    logic [DW-1:0] gi;
    drive_fifo();
    #1;
    s_rden0 = mfifo_rden_o;  s_rden1 = pfifo_rden_o;  s_arvalid = arvalid_o;
    s_arid  = arid_o;        s_araddr = araddr_o;     s_wren = rmfifo_wren_o;
    s_rdata = rmfifo_data_o; s_err = err_o;
    nz0  = (q0.size() != 0);
    nz1  = (q1.size() != 0);
    g    = !m_busy && (nz0 || nz1) && !rmfifo_afull_i && (m_cnt < MO);
    gsrc = (nz0 && nz1) ? m_rr : nz1;
    gi   = '0;
    if (g) gi = gsrc ? q1[0] : q0[0];
    e_rden0   = g && !gsrc;
    e_rden1   = g && gsrc;
    e_arvalid = m_busy && (m_age >= 2);
    e_wren    = e_arvalid && arready_i;
    e_err     = m_err;
    e_arid    = '0;
    e_arid[IDW-1]  = m_src;
    e_arid[TW-1:0] = m_item[DW-1 -: TW];
    e_araddr  = m_item[AW-1:0];
    e_rdata   = {m_src, m_item};
    @(posedge clk);
    if (s_rden0 && q0.size() != 0) begin pop0 = q0.pop_front(); pend0 = 1'b1; end
    if (s_rden1 && q1.size() != 0) begin pop1 = q1.pop_front(); pend1 = 1'b1; end
    if (rdone_i && m_cnt == 0) m_err = 1'b1;
    if (e_wren && !rdone_i) m_cnt++;
    else if (!e_wren && rdone_i && m_cnt > 0) m_cnt--;
    if (g) begin
      m_busy = 1'b1; m_age = 1; m_src = gsrc; m_item = gi;
    end else if (e_wren) begin
      m_busy = 1'b0; m_rr = ~m_src;
    end else if (m_busy && m_age < 2) begin
      m_age++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    q0.delete(); q1.delete();
    pend0 = 1'b0; pend1 = 1'b0;
    arready_i = 1'b0; rdone_i = 1'b0; rmfifo_afull_i = 1'b0;
    mfifo_aempty_i = 1'b1; pfifo_aempty_i = 1'b1;
    m_busy = 1'b0; m_src = 1'b0; m_rr = 1'b0; m_err = 1'b0;
    m_age = 0; m_cnt = 0; m_item = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mfifo_aempty_i = 1'b0; pfifo_aempty_i = 1'b0;
    arready_i = 1'b1; rdone_i = 1'b0; rmfifo_afull_i = 1'b0;
    mfifo_data_i = rand_item(); pfifo_data_i = rand_item();
    @(negedge clk); #1;
    n_checks++; if (arvalid_o !== 1'b0) begin n_errs++; $display("FAIL reset_arvalid: got %b need 0", arvalid_o); end
    n_checks++; if ({mfifo_rden_o, pfifo_rden_o} !== 2'b00) begin n_errs++; $display("FAIL reset_rden: got %b need 00", {mfifo_rden_o, pfifo_rden_o}); end
    n_checks++; if (rmfifo_wren_o !== 1'b0) begin n_errs++; $display("FAIL reset_wren: got %b need 0", rmfifo_wren_o); end
    n_checks++; if (arid_o !== '0 || araddr_o !== '0) begin n_errs++; $display("FAIL reset_ar: got id %h addr %h need 0", arid_o, araddr_o); end
    n_checks++; if (rmfifo_data_o !== '0) begin n_errs++; $display("FAIL reset_rmdata: got %h need 0", rmfifo_data_o); end
    n_checks++; if (err_o !== 1'b0) begin n_errs++; $display("FAIL reset_err: got %b need 0", err_o); end
    apply_reset();
  endtask

  task automatic test_single_miss();
    int t_g, t_v;
    apply_reset();
    arready_i = 1'b1;
    q0.push_back({10'd1, 64'h1});
    t_g = -1; t_v = -1;
    for (int i = 0; i < 8 && t_v < 0; i++) begin
      tick();
      if (s_rden0 && t_g < 0) t_g = cyc - 1;
      if (s_arvalid && t_v < 0) t_v = cyc - 1;
    end
    n_checks++;
    if (t_g < 0 || t_v < 0) begin
      n_errs++; $display("FAIL single_timeout: grant %0d arvalid %0d", t_g, t_v);
    end else begin
      if (t_v - t_g !== 2) begin n_errs++; $display("FAIL single_latency: got %0d need 2", t_v - t_g); end
      n_checks++; if (s_arid !== 16'h0001) begin n_errs++; $display("FAIL single_arid: got %h need 0001", s_arid); end
      n_checks++; if (s_araddr !== 64'h1) begin n_errs++; $display("FAIL single_araddr: got %h need 1", s_araddr); end
      n_checks++; if (s_wren !== 1'b1) begin n_errs++; $display("FAIL single_wren: got %b need 1", s_wren); end
      n_checks++; if (s_rdata !== {1'b0, 10'd1, 64'h1}) begin n_errs++; $display("FAIL single_rmdata: got %h", s_rdata); end
    end
    tick();
    n_checks++; if (s_arvalid !== 1'b0 || s_wren !== 1'b0) begin n_errs++; $display("FAIL single_after: arvalid %b wren %b need 0 0", s_arvalid, s_wren); end
    rdone_i = 1'b1; tick(); rdone_i = 1'b0; tick();
    n_checks++; if (s_err !== 1'b0) begin n_errs++; $display("FAIL single_err: got %b need 0", s_err); end
  endtask

  task automatic test_alternate();
    int nhs, last_c;
    logic last_w;
    apply_reset();
    arready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      q0.push_back({TW'(k), rand_item()[AW-1:0]});
      q1.push_back({TW'(k + 32), rand_item()[AW-1:0]});
    end
    nhs = 0; last_c = 0; last_w = 1'b0;
    for (int i = 0; i < 60 && nhs < 8; i++) begin
      rdone_i = last_w;
      tick();
      last_w = s_wren;
      if (s_wren) begin
        n_checks++; if (s_arid[IDW-1] !== nhs[0]) begin n_errs++; $display("FAIL alt_src%0d: got %b need %b", nhs, s_arid[IDW-1], nhs[0]); end
        if (nhs > 0) begin
          n_checks++; if (cyc - last_c !== 3) begin n_errs++; $display("FAIL alt_spacing%0d: got %0d need 3", nhs, cyc - last_c); end
        end
        last_c = cyc;
        nhs++;
      end
    end
    rdone_i = 1'b0;
    n_checks++; if (nhs !== 8) begin n_errs++; $display("FAIL alt_count: got %0d handshakes need 8", nhs); end
  endtask

  task automatic test_stall();
    logic [IDW-1:0] id0;
    logic [AW-1:0]  ad0;
    bit seen;
    apply_reset();
    arready_i = 1'b0;
    q0.push_back({10'h2A5, 64'hDEAD_BEEF_0123_4567});
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin tick(); seen = s_arvalid; end
    n_checks++;
    if (!seen) begin
      n_errs++; $display("FAIL stall_timeout: arvalid never rose");
    end else begin
      id0 = s_arid; ad0 = s_araddr;
      for (int k = 0; k < 4; k++) begin
        tick();
        n_checks++;
        if (s_arvalid !== 1'b1 || s_wren !== 1'b0 || s_arid !== id0 || s_araddr !== ad0) begin
          n_errs++; $display("FAIL stall_hold%0d: v %b w %b id %h addr %h need 1 0 %h %h", k, s_arvalid, s_wren, s_arid, s_araddr, id0, ad0);
        end
      end
      arready_i = 1'b1; tick();
      n_checks++; if (s_wren !== 1'b1 || s_rdata !== {1'b0, 10'h2A5, 64'hDEAD_BEEF_0123_4567}) begin n_errs++; $display("FAIL stall_hs: wren %b data %h", s_wren, s_rdata); end
      arready_i = 1'b0; tick();
      n_checks++; if (s_arvalid !== 1'b0 || s_wren !== 1'b0) begin n_errs++; $display("FAIL stall_after: v %b w %b need 0 0", s_arvalid, s_wren); end
    end
  endtask

  task automatic test_max_out();
    int grants;
    apply_reset();
    arready_i = 1'b1;
    repeat (3) q0.push_back(rand_item());
    grants = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (s_rden0) grants++; end
    n_checks++; if (grants !== 2) begin n_errs++; $display("FAIL max_block: got %0d grants need 2", grants); end
    rdone_i = 1'b1; tick();
    n_checks++; if (s_rden0 !== 1'b0) begin n_errs++; $display("FAIL max_rdone_cycle: got rden %b need 0", s_rden0); end
    rdone_i = 1'b0; tick();
    n_checks++; if (s_rden0 !== 1'b1) begin n_errs++; $display("FAIL max_regrant: got rden %b need 1", s_rden0); end
    tick();
    rdone_i = 1'b1; tick(); rdone_i = 1'b0;
    n_checks++; if (s_wren !== 1'b1) begin n_errs++; $display("FAIL max_coinc_hs: got wren %b need 1", s_wren); end
    repeat (2) q0.push_back(rand_item());
    grants = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (s_rden0) grants++; end
    n_checks++; if (grants !== 1) begin n_errs++; $display("FAIL max_coinc_count: got %0d grants need 1", grants); end
  endtask

  task automatic test_afull();
    apply_reset();
    rmfifo_afull_i = 1'b1;
    q1.push_back(rand_item());
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if ({s_rden0, s_rden1} !== 2'b00) begin n_errs++; $display("FAIL afull_block%0d: got %b need 00", i, {s_rden0, s_rden1}); end
    end
    rmfifo_afull_i = 1'b0; tick();
    n_checks++; if ({s_rden0, s_rden1} !== 2'b01) begin n_errs++; $display("FAIL afull_release: got %b need 01", {s_rden0, s_rden1}); end
  endtask

  task automatic test_err();
    bit seen;
    apply_reset();
    rdone_i = 1'b1; tick(); rdone_i = 1'b0; tick();
    n_checks++; if (s_err !== 1'b1) begin n_errs++; $display("FAIL err_set: got %b need 1", s_err); end
    repeat (3) tick();
    n_checks++; if (s_err !== 1'b1) begin n_errs++; $display("FAIL err_sticky: got %b need 1", s_err); end
    arready_i = 1'b0;
    q0.push_back(rand_item());
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin tick(); seen = s_arvalid; end
    n_checks++;
    if (!seen) begin
      n_errs++; $display("FAIL err_issue_timeout: arvalid never rose");
    end else begin
      #2 rst = 1'b1;
      #1;
      n_checks++; if (arvalid_o !== 1'b0) begin n_errs++; $display("FAIL rst_async_arvalid: got %b need 0", arvalid_o); end
      n_checks++; if (err_o !== 1'b0) begin n_errs++; $display("FAIL rst_async_err: got %b need 0", err_o); end
    end
    apply_reset();
    tick();
    n_checks++; if (s_arvalid !== 1'b0 || s_err !== 1'b0) begin n_errs++; $display("FAIL rst_after: v %b err %b need 0 0", s_arvalid, s_err); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0 && q0.size() < 4) q0.push_back(rand_item());
      if ($urandom_range(3) == 0 && q1.size() < 4) q1.push_back(rand_item());
      rmfifo_afull_i = ($urandom_range(4) == 0);
      arready_i      = $urandom_range(1);
      rdone_i        = (m_cnt > 0) && ($urandom_range(2) == 0);
      tick();
      n_checks++;
      if ({s_rden0, s_rden1, s_arvalid, s_wren, s_err} !== {e_rden0, e_rden1, e_arvalid, e_wren, e_err}) begin
        n_errs++; $display("FAIL rnd_ctrl@%0d: got %b need %b", cyc, {s_rden0, s_rden1, s_arvalid, s_wren, s_err}, {e_rden0, e_rden1, e_arvalid, e_wren, e_err});
      end
      if (e_arvalid) begin
        n_checks++;
        if (s_arid !== e_arid || s_araddr !== e_araddr) begin
          n_errs++; $display("FAIL rnd_ar@%0d: got %h/%h need %h/%h", cyc, s_arid, s_araddr, e_arid, e_araddr);
        end
      end
      if (e_wren) begin
        n_checks++;
        if (s_rdata !== e_rdata) begin n_errs++; $display("FAIL rnd_rmdata@%0d: got %h need %h", cyc, s_rdata, e_rdata); end
      end
    end
    rdone_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pend0 = 1'b0; pend1 = 1'b0;
    test_reset();
    test_single_miss();
    test_alternate();
    test_stall();
    test_max_out();
    test_afull();
    test_err();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
